// File: rtl/ifetch_if.sv
// Instruction-fetch port bundle: the imem request/response, the redirect
// input from execute, and the decode-side valid/ready instruction stream.
// Valid/ready: a head instruction transfers on a rising edge where
// inst_valid and inst_ready are both 1; while inst_valid is 1 and
// inst_ready is 0 the head fields hold, and inst_valid only drops after a
// transfer, a redirect or a reset.
interface ifetch_if #(
    parameter int CW = 2
);
    logic          imem_en;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          inst_adel;
    logic [CW-1:0] q_count;

    // Fetch unit side.
    modport master (
        output imem_en, imem_addr, inst_valid, inst, inst_pc, inst_adel, q_count,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    // Memory / execute / decode side.
    modport slave (
        input  imem_en, imem_addr, inst_valid, inst, inst_pc, inst_adel, q_count,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the fetch PC, reads the combinational
// instruction memory and buffers {pc, word, adel} entries in a small FIFO
// drained by decode. A misaligned PC produces one address-error entry and
// parks fetch until the next redirect.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h9fc00000,
    parameter int          DEPTH    = 2,
    parameter int          CW       = 2
) (
    input  logic     clk,
    input  logic     resetn,
    ifetch_if.master bus
);
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   fpc_q, fpc_d;
    logic          halted_q, halted_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] word_mem [DEPTH];
    logic        adel_mem [DEPTH];

    logic pop;
    logic fire;
    logic aligned;
    logic full;

    // Handshake decode and next-state computation for PC, halt flag and queue.
    always_comb begin
        full    = (count_q == FULL_CNT);
        aligned = (fpc_q[1:0] == 2'b00);
        pop     = (count_q != '0) && bus.inst_ready;
        fire    = !halted_q && !bus.redirect_valid && (!full || pop);

        fpc_d    = fpc_q;
        halted_d = halted_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (bus.redirect_valid) begin
            // The pop in this cycle still completes; everything else is dropped.
            fpc_d    = bus.redirect_pc;
            halted_d = 1'b0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (aligned) begin
                    fpc_d = fpc_q + 32'd4;
                end else begin
                    halted_d = 1'b1;
                end
            end
            if (fire && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !fire) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fpc_q    <= RESET_PC;
            halted_q <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            halted_q <= halted_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage is written on every push and never reset.
    always_ff @(posedge clk) begin
        if (resetn && fire) begin
            pc_mem[wr_ptr_q]   <= fpc_q;
            word_mem[wr_ptr_q] <= aligned ? bus.imem_rdata : 32'h0;
            adel_mem[wr_ptr_q] <= !aligned;
        end
    end

    // Memory request and queue-head outputs.
    always_comb begin
        bus.imem_en    = fire && aligned;
        bus.imem_addr  = fpc_q;
        bus.inst_valid = (count_q != '0);
        bus.inst       = word_mem[rd_ptr_q];
        bus.inst_pc    = pc_mem[rd_ptr_q];
        bus.inst_adel  = adel_mem[rd_ptr_q];
        bus.q_count    = count_q;
    end
endmodule
